noc_axi4_write_arbiter: RTL and testbench
=========================================

// Module: noc_axi4_write_arbiter
// PURPOSE
//  Shares one AXI4 write engine (NoC->AXI write path) between NUM_REQ NoC requesters.
//  Round-robin arbitration, per-requester outstanding-write limit, AXI ID = requester index.
//  B-channel completions are routed back to the issuing requester by ID.
//  Sits between the NoC deserialisers and the write engine's req_*/resp_* ports.
// PARAMETERS
//  NUM_REQ      4    number of requesters (>=2)
//  MAX_OUTST    4    max outstanding writes per requester (>=1)
//  ADDR_W       64   request address width
//  SIZE_W       3    request size_log width
//  ID_W         16   AXI ID width (>= $clog2(NUM_REQ))
//  DATA_W       512  request data width; strobe width is DATA_W/8
// PORTS
//  clk          in   1                clock
//  rst_n        in   1                synchronous, active-low reset
//  up_req_val   in   NUM_REQ          per-requester write request valid
//  up_req_addr  in   NUM_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  up_req_size  in   NUM_REQ*SIZE_W   packed size_log
//  up_req_data  in   NUM_REQ*DATA_W   packed write data
//  up_req_strb  in   NUM_REQ*DATA_W/8 packed byte strobes
//  up_req_rdy   out  NUM_REQ          per-requester accept
//  up_resp_val  out  NUM_REQ          per-requester write-complete valid
//  up_resp_rdy  in   NUM_REQ          per-requester write-complete ready
//  req_val      out  1                request to write engine
//  req_addr     out  ADDR_W           |
//  req_size_log out  SIZE_W           | held stable while req_val && !req_rdy
//  req_id       out  ID_W             | zero-extended requester index
//  req_data     out  DATA_W           |
//  req_strb     out  DATA_W/8         |
//  req_rdy      in   1                write engine accept
//  resp_val     in   1                write engine completion valid
//  resp_id      in   ID_W             completion ID
//  resp_rdy     out  1                completion accept
//  err_bad_id   out  1                sticky: completion with ID >= NUM_REQ received
// BEHAVIOUR
//  Reset: req_val=0, output regs=0, rr_ptr=0, all outst_cnt=0, err_bad_id=0.
//  Eligible(i) = up_req_val[i] && outst_cnt[i] < MAX_OUTST.
//  Grant: combinational round-robin over eligible, search from rr_ptr upward with wrap.
//  One output register (slot): load_en = !req_val || req_rdy.
//  up_req_rdy[i] = load_en && grant==i; at most one bit set; 0 when nothing eligible.
//  On up handshake for i: slot <= requester i fields, req_id <= i, req_val <= 1 next cycle,
//   rr_ptr <= (i+1) mod NUM_REQ, outst_cnt[i] += 1. Latency: up accept -> req_val = 1 cycle.
//  On req_rdy with no new load: req_val <= 0. Back-to-back: accept and emit every cycle.
//  rr_ptr changes only on an up handshake; no grant, no pointer move.
//  Completion routing: idx = resp_id. idx<NUM_REQ: up_resp_val[idx]=resp_val,
//   resp_rdy=up_resp_rdy[idx]; handshake decrements outst_cnt[idx].
//  idx>=NUM_REQ: resp_rdy=1 (drop), up_resp_val=0, err_bad_id <= 1 (sticky until reset).
//  Same-cycle inc and dec on one counter: net unchanged. Counter width $clog2(MAX_OUTST+1).
//  Decrement at 0: prohibited; counter saturates at 0 (assertion in sim).
//  Counting at issue (not at req_rdy) keeps the slot entry within the limit.
//  Reset mid-operation: slot, counters, pointer, and error flag cleared; in-flight
//   completions arriving after reset are out of contract.
//  No combinational path from req_rdy to req_* data; up_req_rdy depends on req_rdy.
// TESTING
//  T1 reset: up_req_val=4'b1111 held in reset -> up_req_rdy=0, req_val=0, err_bad_id=0.
//  T2 RR fairness: all 4 valid, req_rdy=1 -> req_id sequence 0,1,2,3,0,... one per cycle.
//  T3 backpressure: req_rdy=0 for 5 cycles -> req_* stable, up_req_rdy=0; release -> next id.
//  T4 limit: MAX_OUTST=4, only req0 valid, no resp -> 4 issues then up_req_rdy[0]=0;
//     one resp_id=0 handshake -> exactly one more issue.
//  T5 routing: resp_id=2, up_resp_rdy=4'b0100 -> up_resp_val=4'b0100, resp_rdy=1, cnt[2]-1.
//     resp_id=7 -> resp_rdy=1, up_resp_val=0, err_bad_id=1 and stays 1.
//  T6 simultaneous issue+complete on req1 at cnt=MAX_OUTST-1 -> cnt unchanged, no overflow.

Source files
------------

// File: rtl/noc_axi4_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write engine among NoC requesters.
// up_req_* in, req_*/resp_* to engine, up_resp_* out, err_bad_id sticky.
module noc_axi4_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 64,
  parameter int SIZE_W    = 3,
  parameter int ID_W      = 16,
  parameter int DATA_W    = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          up_req_val,
  input  logic [NUM_REQ*ADDR_W-1:0]   up_req_addr,
  input  logic [NUM_REQ*SIZE_W-1:0]   up_req_size,
  input  logic [NUM_REQ*DATA_W-1:0]   up_req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] up_req_strb,
  output logic [NUM_REQ-1:0]          up_req_rdy,
  output logic [NUM_REQ-1:0]          up_resp_val,
  input  logic [NUM_REQ-1:0]          up_resp_rdy,
  output logic                        req_val,
  output logic [ADDR_W-1:0]           req_addr,
  output logic [SIZE_W-1:0]           req_size_log,
  output logic [ID_W-1:0]             req_id,
  output logic [DATA_W-1:0]           req_data,
  output logic [DATA_W/8-1:0]         req_strb,
  input  logic                        req_rdy,
  input  logic                        resp_val,
  input  logic [ID_W-1:0]             resp_id,
  output logic                        resp_rdy,
  output logic                        err_bad_id
);

  localparam int STRB_W = DATA_W/8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_OUTST+1);

  logic [CNT_W-1:0]  outst_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  outst_cnt_d [NUM_REQ];
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              req_val_q, req_val_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] inc_v, dec_v;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic               load_en, up_hs;
  logic               id_ok, resp_hs;
  logic [IDX_W-1:0]   resp_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = up_req_val[i] &&
                (outst_cnt_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  assign load_en = !req_val_q || req_rdy;
  assign up_hs   = rst_n && load_en && gnt_vld;

  always_comb begin
    up_req_rdy = '0;
    if (up_hs) up_req_rdy[gnt_idx] = 1'b1;
  end

  // Unknown IDs are swallowed so the engine never stalls on them.
  assign id_ok    = resp_id < ID_W'(NUM_REQ);
  assign resp_idx = resp_id[IDX_W-1:0];

  always_comb begin
    up_resp_val = '0;
    resp_rdy    = 1'b1;
    if (id_ok) begin
      up_resp_val[resp_idx] = resp_val;
      resp_rdy              = up_resp_rdy[resp_idx];
    end
  end

  assign resp_hs = resp_val && resp_rdy && id_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_v[i] = up_hs && (gnt_idx == IDX_W'(i));
      dec_v[i] = resp_hs && (resp_idx == IDX_W'(i));
      outst_cnt_d[i] = outst_cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        outst_cnt_d[i] = outst_cnt_q[i] + 1'b1;
      end else if (dec_v[i] && !inc_v[i] &&
                   outst_cnt_q[i] != '0) begin
        outst_cnt_d[i] = outst_cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    req_val_d = req_val_q;
    addr_d    = addr_q;
    size_d    = size_q;
    id_d      = id_q;
    data_d    = data_q;
    strb_d    = strb_q;
    rr_ptr_d  = rr_ptr_q;
    if (up_hs) begin
      req_val_d = 1'b1;
      addr_d    = up_req_addr[gnt_idx*ADDR_W +: ADDR_W];
      size_d    = up_req_size[gnt_idx*SIZE_W +: SIZE_W];
      data_d    = up_req_data[gnt_idx*DATA_W +: DATA_W];
      strb_d    = up_req_strb[gnt_idx*STRB_W +: STRB_W];
      id_d      = ID_W'(gnt_idx);
      rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ-1)) ?
                  '0 : gnt_idx + 1'b1;
    end else if (req_rdy) begin
      req_val_d = 1'b0;
    end
    err_d = err_q | (resp_val && !id_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_val_q <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      id_q      <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outst_cnt_q[i] <= '0;
    end else begin
      req_val_q <= req_val_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      id_q      <= id_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_REQ; i++) outst_cnt_q[i] <= outst_cnt_d[i];
    end
  end

  // A completion for a requester with nothing outstanding is illegal.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(dec_v[i] && !inc_v[i] && outst_cnt_q[i] == '0));
      end
    end
  end

  assign req_val      = req_val_q;
  assign req_addr     = addr_q;
  assign req_size_log = size_q;
  assign req_id       = id_q;
  assign req_data     = data_q;
  assign req_strb     = strb_q;
  assign err_bad_id   = err_q;

endmodule

// File: tb/tb_noc_axi4_write_arbiter.sv
// Testbench for noc_axi4_write_arbiter: scenario tasks plus a randomized
// run, all checked against a transaction-level model of the arbiter.
module tb_noc_axi4_write_arbiter;

  localparam int NR = 4;
  localparam int MO = 4;
  localparam int AW = 64;
  localparam int SW = 3;
  localparam int IW = 16;
  localparam int DW = 512;
  localparam int BW = DW/8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    up_req_val;
  logic [NR*AW-1:0] up_req_addr;
  logic [NR*SW-1:0] up_req_size;
  logic [NR*DW-1:0] up_req_data;
  logic [NR*BW-1:0] up_req_strb;
  logic [NR-1:0]    up_req_rdy;
  logic [NR-1:0]    up_resp_val;
  logic [NR-1:0]    up_resp_rdy;
  logic             req_val;
  logic [AW-1:0]    req_addr;
  logic [SW-1:0]    req_size_log;
  logic [IW-1:0]    req_id;
  logic [DW-1:0]    req_data;
  logic [BW-1:0]    req_strb;
  logic             req_rdy;
  logic             resp_val;
  logic [IW-1:0]    resp_id;
  logic             resp_rdy;
  logic             err_bad_id;

  noc_axi4_write_arbiter #(
    .NUM_REQ(NR), .MAX_OUTST(MO), .ADDR_W(AW),
    .SIZE_W(SW), .ID_W(IW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_val(up_req_val), .up_req_addr(up_req_addr),
    .up_req_size(up_req_size), .up_req_data(up_req_data),
    .up_req_strb(up_req_strb), .up_req_rdy(up_req_rdy),
    .up_resp_val(up_resp_val), .up_resp_rdy(up_resp_rdy),
    .req_val(req_val), .req_addr(req_addr),
    .req_size_log(req_size_log), .req_id(req_id),
    .req_data(req_data), .req_strb(req_strb),
    .req_rdy(req_rdy), .resp_val(resp_val),
    .resp_id(resp_id), .resp_rdy(resp_rdy),
    .err_bad_id(err_bad_id)
  );

  logic [AW-1:0] addr_a [NR];
  logic [SW-1:0] size_a [NR];
  logic [DW-1:0] data_a [NR];
  logic [BW-1:0] strb_a [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      up_req_addr[i*AW +: AW] = addr_a[i];
      up_req_size[i*SW +: SW] = size_a[i];
      up_req_data[i*DW +: DW] = data_a[i];
      up_req_strb[i*BW +: BW] = strb_a[i];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: transaction-level view of the arbiter.
  int            m_cnt [NR];
  int            m_ptr;
  bit            m_val;
  int            m_id;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_strb;
  bit            m_err;

  logic [NR-1:0] e_up_rdy, e_up_resp_val;
  logic          e_resp_rdy;
  logic [NR-1:0] o_up_rdy, o_up_resp_val;
  logic          o_resp_rdy;

  task automatic rnd_fields();
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = {$urandom, $urandom};
      size_a[i] = SW'($urandom);
      strb_a[i] = '0;
      for (int w = 0; w < DW/32; w++) data_a[i][w*32 +: 32] = $urandom;
      for (int w = 0; w < BW/32; w++) strb_a[i][w*32 +: 32] = $urandom;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_ptr = 0; m_val = 0; m_id = 0; m_err = 0;
    m_addr = '0; m_size = '0; m_data = '0; m_strb = '0;
  endtask

  // One clock: predict and sample combinational outputs mid-cycle,
  // then advance the model at the edge.
  task automatic cyc();
    int g;
    int j;
    int rid;
    bit load;
    @(negedge clk);
    load = !m_val || req_rdy;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (g < 0 && up_req_val[j] && m_cnt[j] < MO) g = j;
    end
    if (!(rst_n && load)) g = -1;
    e_up_rdy = '0;
    if (g >= 0) e_up_rdy[g] = 1'b1;
    rid = int'(resp_id);
    e_up_resp_val = '0;
    e_resp_rdy = 1'b1;
    if (rid < NR) begin
      e_up_resp_val[rid] = resp_val;
      e_resp_rdy = up_resp_rdy[rid];
    end
    o_up_rdy = up_req_rdy;
    o_up_resp_val = up_resp_val;
    o_resp_rdy = resp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_cnt[g]++;
        m_ptr = (g + 1) % NR;
        m_val = 1; m_id = g;
        m_addr = addr_a[g]; m_size = size_a[g];
        m_data = data_a[g]; m_strb = strb_a[g];
      end else if (req_rdy) begin
        m_val = 0;
      end
      if (resp_val && e_resp_rdy) begin
        if (rid < NR) m_cnt[rid]--;
        else m_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    up_req_val = '0; up_resp_rdy = '0; req_rdy = 1'b0;
    resp_val = 1'b0; resp_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rnd_fields();
    rst_n = 1'b0;
    up_req_val = 4'b1111;
    req_rdy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      n_chk++;
      if (o_up_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_up_rdy: got %b want 0000", o_up_rdy);
      end
      n_chk++;
      if (req_val !== 1'b0 || err_bad_id !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outs: req_val=%b err=%b want 0 0",
                 req_val, err_bad_id);
      end
    end
    rst_n = 1'b1;
    cyc();
    n_chk++;
    if (req_val !== 1'b1 || req_id !== IW'(0) || req_addr !== addr_a[0]) begin
      n_fail++;
      $display("FAIL reset_first: val=%b id=%0d want 1 0", req_val, req_id);
    end
  endtask

  task automatic test_rr();
    do_reset();
    up_req_val = 4'b1111;
    req_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rnd_fields();
      cyc();
      n_chk++;
      if (req_val !== 1'b1 || req_id !== IW'(n % NR)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: val=%b id=%0d want 1 %0d",
                 n, req_val, req_id, n % NR);
      end
      n_chk++;
      if (req_addr !== m_addr || req_data !== m_data ||
          req_strb !== m_strb || req_size_log !== m_size) begin
        n_fail++;
        $display("FAIL rr_payload[%0d]: addr=%h want %h",
                 n, req_addr, m_addr);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] s_id;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    do_reset();
    up_req_val = 4'b1111;
    req_rdy = 1'b1;
    rnd_fields();
    cyc(); cyc();
    s_id = req_id; s_addr = req_addr; s_data = req_data;
    req_rdy = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rnd_fields();
      cyc();
      n_chk++;
      if (o_up_rdy !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_up_rdy[%0d]: got %b want 0000", n, o_up_rdy);
      end
      n_chk++;
      if (req_val !== 1'b1 || req_id !== s_id ||
          req_addr !== s_addr || req_data !== s_data) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: id=%0d addr=%h want %0d %h",
                 n, req_id, req_addr, s_id, s_addr);
      end
    end
    req_rdy = 1'b1;
    cyc();
    n_chk++;
    if (req_val !== 1'b1 || req_id !== IW'(2) || req_addr !== m_addr) begin
      n_fail++;
      $display("FAIL bp_release: id=%0d want 2", req_id);
    end
  endtask

  task automatic test_limit();
    int issues;
    do_reset();
    rnd_fields();
    up_req_val = 4'b0001;
    req_rdy = 1'b1;
    issues = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (o_up_rdy[0]) issues++;
    end
    n_chk++;
    if (issues != MO || o_up_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL limit_fill: issues=%0d rdy=%b want %0d 0000",
               issues, o_up_rdy, MO);
    end
    resp_val = 1'b1; resp_id = '0; up_resp_rdy = 4'b0001;
    cyc();
    issues = o_up_rdy[0] ? 1 : 0;
    n_chk++;
    if (o_resp_rdy !== 1'b1 || o_up_resp_val !== 4'b0001) begin
      n_fail++;
      $display("FAIL limit_resp: rdy=%b uval=%b want 1 0001",
               o_resp_rdy, o_up_resp_val);
    end
    resp_val = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc();
      if (o_up_rdy[0]) issues++;
    end
    n_chk++;
    if (issues != 1) begin
      n_fail++;
      $display("FAIL limit_refill: issues=%0d want 1", issues);
    end
  endtask

  task automatic test_routing();
    do_reset();
    rnd_fields();
    up_req_val = 4'b0100;
    req_rdy = 1'b1;
    cyc(); cyc();
    up_req_val = '0;
    resp_val = 1'b1; resp_id = IW'(2); up_resp_rdy = 4'b0000;
    cyc();
    n_chk++;
    if (o_resp_rdy !== 1'b0 || o_up_resp_val !== 4'b0100) begin
      n_fail++;
      $display("FAIL route_blocked: rdy=%b uval=%b want 0 0100",
               o_resp_rdy, o_up_resp_val);
    end
    up_resp_rdy = 4'b0100;
    cyc();
    n_chk++;
    if (o_resp_rdy !== 1'b1 || o_up_resp_val !== 4'b0100) begin
      n_fail++;
      $display("FAIL route_ok: rdy=%b uval=%b want 1 0100",
               o_resp_rdy, o_up_resp_val);
    end
    n_chk++;
    if (int'(dut.outst_cnt_q[2]) != m_cnt[2] || m_cnt[2] != 1) begin
      n_fail++;
      $display("FAIL route_cnt: got %0d want 1", dut.outst_cnt_q[2]);
    end
    resp_id = IW'(7); up_resp_rdy = 4'b0000;
    cyc();
    n_chk++;
    if (o_resp_rdy !== 1'b1 || o_up_resp_val !== 4'b0000 ||
        err_bad_id !== 1'b1) begin
      n_fail++;
      $display("FAIL route_bad: rdy=%b uval=%b err=%b want 1 0000 1",
               o_resp_rdy, o_up_resp_val, err_bad_id);
    end
    resp_val = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      n_chk++;
      if (err_bad_id !== 1'b1) begin
        n_fail++;
        $display("FAIL route_sticky[%0d]: err=%b want 1", n, err_bad_id);
      end
    end
  endtask

  task automatic test_simul();
    do_reset();
    rnd_fields();
    up_req_val = 4'b0010;
    req_rdy = 1'b1;
    cyc(); cyc(); cyc();
    n_chk++;
    if (int'(dut.outst_cnt_q[1]) != MO-1) begin
      n_fail++;
      $display("FAIL simul_pre: cnt=%0d want %0d", dut.outst_cnt_q[1], MO-1);
    end
    resp_val = 1'b1; resp_id = IW'(1); up_resp_rdy = 4'b0010;
    cyc();
    n_chk++;
    if (o_up_rdy !== 4'b0010 || o_resp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_hs: up_rdy=%b resp_rdy=%b want 0010 1",
               o_up_rdy, o_resp_rdy);
    end
    resp_val = 1'b0; up_req_val = '0;
    cyc();
    n_chk++;
    if (int'(dut.outst_cnt_q[1]) != MO-1 || req_id !== IW'(1)) begin
      n_fail++;
      $display("FAIL simul_cnt: cnt=%0d id=%0d want %0d 1",
               dut.outst_cnt_q[1], req_id, MO-1);
    end
  endtask

  task automatic test_random();
    int r;
    int s;
    int pick;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rnd_fields();
      up_req_val = NR'($urandom);
      req_rdy = ($urandom_range(0, 3) != 0);
      up_resp_rdy = NR'($urandom);
      resp_val = 1'b0; resp_id = '0;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        resp_val = 1'b1;
        resp_id = IW'($urandom_range(NR, 300));
      end else if (r < 10) begin
        s = $urandom_range(0, NR-1);
        pick = -1;
        for (int k = 0; k < NR; k++)
          if (pick < 0 && m_cnt[(s+k)%NR] > 0) pick = (s+k)%NR;
        if (pick >= 0) begin
          resp_val = 1'b1;
          resp_id = IW'(pick);
        end
      end
      cyc();
      n_chk++;
      if (o_up_rdy !== e_up_rdy) begin
        n_fail++;
        $display("FAIL rnd_up_rdy[%0d]: got %b want %b", n, o_up_rdy, e_up_rdy);
      end
      n_chk++;
      if (o_up_resp_val !== e_up_resp_val || o_resp_rdy !== e_resp_rdy) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: uval=%b rdy=%b want %b %b",
                 n, o_up_resp_val, o_resp_rdy, e_up_resp_val, e_resp_rdy);
      end
      n_chk++;
      if (req_val !== m_val || req_id !== IW'(m_id) ||
          req_addr !== m_addr || req_size_log !== m_size ||
          req_data !== m_data || req_strb !== m_strb) begin
        n_fail++;
        $display("FAIL rnd_slot[%0d]: val=%b id=%0d addr=%h want %b %0d %h",
                 n, req_val, req_id, req_addr, m_val, m_id, m_addr);
      end
      n_chk++;
      if (err_bad_id !== m_err) begin
        n_fail++;
        $display("FAIL rnd_err[%0d]: got %b want %b", n, err_bad_id, m_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    rnd_fields();
    model_reset();
    test_reset();
    test_rr();
    test_backpressure();
    test_limit();
    test_routing();
    test_simul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
